sel_rr_arb: RTL and testbench

Round-robin arbiter that shares one `W`-bit output channel between `N` valid/ready requesters. The winner's payload is steered through the existing one-hot `sel` datapath into a single registered output stage. This makes it the sequencing/control front end for any `sel`-based shared resource. Full throughput is sustained: one transfer per cycle when the consumer is ready.

---
 rtl/sel_rr_arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 38 +++
 rtl/sel.sv | 21 ++
 rtl/sel_rr_arb.sv | 99 +++++++++
 tb/tb_sel_rr_arb.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sel_rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter front end.
// PTR_W(n) sizes the priority pointer; never narrower than one bit.
package sel_rr_arb_pkg;

    function automatic int unsigned PTR_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of i_vld scanning cyclically upward from i_ptr.
// Double-width priority encode with the pointer-masked copy taking precedence.
module rr_pick
    import sel_rr_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          i_vld,
    input  logic [PTR_W(N)-1:0]   i_ptr,
    output logic [N-1:0]          o_gnt
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_gnt;
    logic           found;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= 32'(i_ptr));
        end

        // Low half: requests at or above ptr; high half: all requests, used on wrap.
        dbl     = {i_vld, i_vld & mask};
        dbl_gnt = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (dbl[i] && !found) begin
                dbl_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end

        o_gnt = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
    end

endmodule

// File: rtl/sel.sv
// One-hot AND-OR payload selector: o_data is the slice of i_data whose i_sel bit is set.
// An all-zero select yields zero.
module sel #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4
) (
    input  logic [N*W-1:0] i_data,
    input  logic [N-1:0]   i_sel,
    output logic [W-1:0]   o_data
);

    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_sel[i]) begin
                o_data = o_data | i_data[W*i +: W];
            end
        end
    end

endmodule

// File: rtl/sel_rr_arb.sv
// Round-robin arbiter sharing one registered W-bit output among N valid/ready requesters.
// Winner payload is steered through the one-hot sel datapath; one transfer per cycle.
module sel_rr_arb
    import sel_rr_arb_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           arst,
    input  logic [N-1:0]   i_req_vld,
    input  logic [N*W-1:0] i_req_data,
    output logic [N-1:0]   o_req_rdy,
    output logic           o_vld,
    output logic [W-1:0]   o_data,
    output logic [N-1:0]   o_gnt,
    input  logic           i_rdy
);

    localparam int unsigned PtrW = PTR_W(N);

    logic            vld_q, vld_d;
    logic [W-1:0]    data_q, data_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [PtrW-1:0] ptr_q, ptr_d;

    logic            ld;
    logic [N-1:0]    gnt;
    logic [W-1:0]    sel_data;
    logic [PtrW-1:0] gnt_idx;

    rr_pick #(
        .N(N)
    ) u_rr_pick (
        .i_vld (i_req_vld),
        .i_ptr (ptr_q),
        .o_gnt (gnt)
    );

    sel #(
        .W(W),
        .N(N)
    ) u_sel (
        .i_data (i_req_data),
        .i_sel  (gnt),
        .o_data (sel_data)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = PtrW'(i);
            end
        end
    end

    assign ld = !vld_q || i_rdy;

    // Gated by arst so nothing handshakes while the output register is being cleared.
    assign o_req_rdy = (ld && !arst) ? gnt : '0;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        gnt_d  = gnt_q;
        ptr_d  = ptr_q;
        if (ld) begin
            if (|gnt) begin
                vld_d  = 1'b1;
                data_d = sel_data;
                gnt_d  = gnt;
                ptr_d  = (gnt_idx == PtrW'(N - 1)) ? '0 : gnt_idx + PtrW'(1);
            end else begin
                vld_d = 1'b0;
                gnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            gnt_q  <= '0;
            ptr_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            gnt_q  <= gnt_d;
            ptr_q  <= ptr_d;
        end
    end

    assign o_vld  = vld_q;
    assign o_data = data_q;
    assign o_gnt  = gnt_q;

endmodule

// File: tb/tb_sel_rr_arb.sv
// Scoreboard bench for sel_rr_arb (N=4, W=8): a round-robin model predicts each grant and
// queues the expected payload; an independent monitor checks the output register against it.
module tb_sel_rr_arb;

    localparam int W = 8;
    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [W-1:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           arst;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic           o_vld;
    logic [W-1:0]   o_data;
    logic [N-1:0]   o_gnt;
    logic           i_rdy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   mptr;
    int   granted;
    logic [N-1:0] sticky;

    always #5 clk = ~clk;

    sel_rr_arb #(
        .W(W),
        .N(N)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .i_req_vld  (req_vld),
        .i_req_data (req_data),
        .o_req_rdy  (req_rdy),
        .o_vld      (o_vld),
        .o_data     (o_data),
        .o_gnt      (o_gnt),
        .i_rdy      (i_rdy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: output register must show the oldest queued payload; pop on consumer accept.
    always @(negedge clk) begin
        if (!arst) begin
            if (sb.size() == 0) begin
                chk("o_vld_empty", 32'(o_vld), 32'd0);
                chk("o_gnt_idle", 32'(o_gnt), 32'd0);
            end else begin
                chk("o_vld_full", 32'(o_vld), 32'd1);
                chk("o_data", 32'(o_data), 32'(sb[0].data));
                chk("o_gnt", 32'(o_gnt), 32'(sb[0].gnt));
                if (i_rdy) void'(sb.pop_front());
            end
        end
    end

    // Reference: cyclic scan from the model pointer; the queue itself is the occupancy state.
    task automatic model_step();
        logic         ld;
        int           win;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        ld  = i_rdy || (sb.size() == 0);
        win = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (win < 0 && req_vld[j]) win = j;
        end
        exp_rdy = '0;
        if (ld && win >= 0) exp_rdy[win] = 1'b1;
        chk("o_req_rdy", 32'(req_rdy), 32'(exp_rdy));
        granted = -1;
        if (ld && win >= 0) begin
            e.gnt  = exp_rdy;
            e.data = req_data[win*W +: W];
            sb.push_back(e);
            mptr    = (win + 1) % N;
            granted = win;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
        if (granted >= 0 && !sticky[granted]) req_vld[granted] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] d);
        req_vld[i]          = 1'b1;
        req_data[i*W +: W]  = d;
    endtask

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        arst     = 1'b1;
        req_vld  = '0;
        req_data = '0;
        i_rdy    = 1'b0;
        sticky   = '0;
        mptr     = 0;
        granted  = -1;
        #1;
        chk("rst_o_vld", 32'(o_vld), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_o_gnt", 32'(o_gnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;

        // Single request on req1 after reset
        i_rdy = 1'b1;
        set_req(1, 8'h11);
        cycle();
        chk("first_gnt", 32'(o_gnt), 32'h2);
        chk("first_data", 32'(o_data), 32'h11);
        cycles(2);

        // Full rotation, all requesters continuously valid
        sticky = '1;
        for (int i = 0; i < N; i++) set_req(i, 8'hA0 + 8'(i));
        cycles(12);
        req_vld = '0;
        cycles(2);

        // Only req3 and req0: pointer skip and wrap
        set_req(0, 8'h30);
        set_req(3, 8'h33);
        cycles(8);
        req_vld = '0;
        cycles(2);

        // Backpressure with all valid, then release
        for (int i = 0; i < N; i++) set_req(i, 8'hB0 + 8'(i));
        cycles(2);
        i_rdy = 1'b0;
        cycles(5);
        i_rdy = 1'b1;
        cycles(3);
        req_vld = '0;
        cycles(2);

        // Drain to empty from a single req2 payload
        sticky = '0;
        set_req(2, 8'hC2);
        cycles(4);

        // Late arrival: req1 joins a continuous req0
        sticky = 4'b0011;
        set_req(0, 8'hD0);
        cycles(10);
        set_req(1, 8'hD1);
        cycles(8);
        req_vld = '0;
        sticky  = '0;
        cycles(2);

        // Randomised traffic; requesters hold until granted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_vld[i] && $urandom_range(0, 2) == 0) set_req(i, 8'($urandom));
            end
            i_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset mid-cycle with a payload held
        i_rdy = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 8'hE0 + 8'(i));
        cycle();
        #2;
        arst = 1'b1;
        #1;
        chk("mid_rst_o_vld", 32'(o_vld), 32'd0);
        chk("mid_rst_o_data", 32'(o_data), 32'd0);
        chk("mid_rst_o_gnt", 32'(o_gnt), 32'd0);
        chk("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
        sb.delete();
        mptr    = 0;
        req_vld = '0;
        repeat (2) @(posedge clk);
        #1;
        arst  = 1'b0;
        i_rdy = 1'b1;
        set_req(1, 8'h11);
        cycle();
        chk("post_rst_gnt", 32'(o_gnt), 32'h2);
        chk("post_rst_data", 32'(o_data), 32'h11);
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
